// File: rtl/hazard_unit_scoreboard.sv
// RV32I hazard/forwarding controller: load-use stall FSM with configurable latency,
// single-entry MUL/DIV scoreboard, EX operand forwarding and saturating perf counters.
module hazard_unit_scoreboard #(
   parameter int LOAD_LAT = 1,
   parameter int PERF_W   = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [4:0]        ID_rs1_addr,
   input  logic [4:0]        ID_rs2_addr,
   input  logic [4:0]        ID_rd_addr,
   input  logic              ID_rd_wren,
   input  logic              ID_is_mdu,
   input  logic [4:0]        EX_rs1_addr,
   input  logic [4:0]        EX_rs2_addr,
   input  logic [4:0]        EX_rd_addr,
   input  logic              EX_rd_wren,
   input  logic              EX_is_load,
   input  logic              EX_br_sel,
   input  logic              EX_mdu_start,
   input  logic              mdu_done,
   input  logic [4:0]        MEM_rd_addr,
   input  logic [4:0]        WB_rd_addr,
   input  logic              MEM_rd_wren,
   input  logic              WB_rd_wren,
   output logic              stall_IF,
   output logic              stall_ID,
   output logic              flush_ID,
   output logic              flush_EX,
   output logic [1:0]        forward_rs1_sel,
   output logic [1:0]        forward_rs2_sel,
   output logic              mdu_busy,
   output logic [PERF_W-1:0] perf_stall_cnt,
   output logic [PERF_W-1:0] perf_flush_cnt
);

   typedef enum logic {LD_IDLE, LD_STALL} ld_state_t;

   localparam logic [PERF_W-1:0] CNT_ONE = PERF_W'(1);
   localparam logic [PERF_W-1:0] CNT_MAX = {PERF_W{1'b1}};

   ld_state_t         r_state, w_next_state;
   logic [2:0]        r_ld_cnt, w_ld_cnt_nxt;
   logic              r_mdu_busy;
   logic [4:0]        r_mdu_rd;
   logic [PERF_W-1:0] r_stall_cnt, r_flush_cnt;

   logic w_ld_hit, w_mdu_hz, w_hz;
   logic w_rs1_nz, w_rs2_nz;
   logic w_raw_busy, w_raw_start;

   // MEM beats WB; x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] mem_rd, input logic mem_we,
                                          input logic [4:0] wb_rd,  input logic wb_we);
      if (rs == 5'd0)                  return 2'b00;
      else if (mem_we && mem_rd == rs) return 2'b01;
      else if (wb_we && wb_rd == rs)   return 2'b10;
      else                             return 2'b00;
   endfunction

   assign forward_rs1_sel = fwd_sel(EX_rs1_addr, MEM_rd_addr, MEM_rd_wren, WB_rd_addr, WB_rd_wren);
   assign forward_rs2_sel = fwd_sel(EX_rs2_addr, MEM_rd_addr, MEM_rd_wren, WB_rd_addr, WB_rd_wren);

   assign w_rs1_nz = (ID_rs1_addr != 5'd0);
   assign w_rs2_nz = (ID_rs2_addr != 5'd0);

   assign w_ld_hit = EX_is_load && EX_rd_wren && (EX_rd_addr != 5'd0) &&
                     ((EX_rd_addr == ID_rs1_addr) || (EX_rd_addr == ID_rs2_addr));

   assign w_raw_busy  = (w_rs1_nz && ID_rs1_addr == r_mdu_rd) ||
                        (w_rs2_nz && ID_rs2_addr == r_mdu_rd);
   // A freshly launched MDU result cannot be forwarded, so a consumer right behind it waits.
   assign w_raw_start = (w_rs1_nz && ID_rs1_addr == EX_rd_addr) ||
                        (w_rs2_nz && ID_rs2_addr == EX_rd_addr);

   assign w_mdu_hz = (r_mdu_busy && (w_raw_busy || (ID_rd_wren && ID_rd_addr == r_mdu_rd) || ID_is_mdu)) ||
                     (EX_mdu_start && w_raw_start);

   assign w_hz = (r_state == LD_STALL) || w_ld_hit || w_mdu_hz;

   assign stall_IF = w_hz && !EX_br_sel;
   assign stall_ID = w_hz && !EX_br_sel;
   assign flush_ID = EX_br_sel;
   assign flush_EX = EX_br_sel || w_hz;

   assign mdu_busy       = r_mdu_busy;
   assign perf_stall_cnt = r_stall_cnt;
   assign perf_flush_cnt = r_flush_cnt;

   always_comb begin
      w_next_state = r_state;
      w_ld_cnt_nxt = r_ld_cnt;
      case (r_state)
         LD_IDLE: begin
            if (w_ld_hit && !EX_br_sel && (LOAD_LAT > 1)) begin
               w_next_state = LD_STALL;
               w_ld_cnt_nxt = 3'(LOAD_LAT - 1);
            end
         end
         LD_STALL: begin
            if (EX_br_sel) begin
               w_next_state = LD_IDLE;
               w_ld_cnt_nxt = 3'd0;
            end else begin
               w_ld_cnt_nxt = r_ld_cnt - 3'd1;
               if (r_ld_cnt == 3'd1) w_next_state = LD_IDLE;
            end
         end
         default: begin
            w_next_state = LD_IDLE;
            w_ld_cnt_nxt = 3'd0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= LD_IDLE;
         r_ld_cnt <= 3'd0;
      end else begin
         r_state  <= w_next_state;
         r_ld_cnt <= w_ld_cnt_nxt;
      end
   end

   // A start in the same cycle as done wins: the entry is simply reloaded.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mdu_busy <= 1'b0;
         r_mdu_rd   <= 5'd0;
      end else if (EX_mdu_start && EX_rd_addr != 5'd0) begin
         r_mdu_busy <= 1'b1;
         r_mdu_rd   <= EX_rd_addr;
      end else if (mdu_done) begin
         r_mdu_busy <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (stall_ID && r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + CNT_ONE;
         if (flush_ID && r_flush_cnt != CNT_MAX) r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_hazard_unit_scoreboard.sv
// Directed bench: two instances (LOAD_LAT=1/PERF_W=4 and LOAD_LAT=3/PERF_W=16) share stimulus.
module tb_hazard_unit_scoreboard;

   logic i_clk = 1'b0;
   logic i_rst_n;
   logic [4:0] ID_rs1_addr, ID_rs2_addr, ID_rd_addr;
   logic ID_rd_wren, ID_is_mdu;
   logic [4:0] EX_rs1_addr, EX_rs2_addr, EX_rd_addr;
   logic EX_rd_wren, EX_is_load, EX_br_sel, EX_mdu_start, mdu_done;
   logic [4:0] MEM_rd_addr, WB_rd_addr;
   logic MEM_rd_wren, WB_rd_wren;

   logic a_stall_IF, a_stall_ID, a_flush_ID, a_flush_EX, a_mdu_busy;
   logic [1:0] a_fwd1, a_fwd2;
   logic [3:0] a_pstall, a_pflush;
   logic b_stall_IF, b_stall_ID, b_flush_ID, b_flush_EX, b_mdu_busy;
   logic [1:0] b_fwd1, b_fwd2;
   logic [15:0] b_pstall, b_pflush;

   int errs = 0;
   int checks = 0;
   int flush_before;

   always #5 i_clk = ~i_clk;

   hazard_unit_scoreboard #(.LOAD_LAT(1), .PERF_W(4)) u_lat1 (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr), .ID_rd_addr(ID_rd_addr),
      .ID_rd_wren(ID_rd_wren), .ID_is_mdu(ID_is_mdu),
      .EX_rs1_addr(EX_rs1_addr), .EX_rs2_addr(EX_rs2_addr), .EX_rd_addr(EX_rd_addr),
      .EX_rd_wren(EX_rd_wren), .EX_is_load(EX_is_load), .EX_br_sel(EX_br_sel),
      .EX_mdu_start(EX_mdu_start), .mdu_done(mdu_done),
      .MEM_rd_addr(MEM_rd_addr), .WB_rd_addr(WB_rd_addr),
      .MEM_rd_wren(MEM_rd_wren), .WB_rd_wren(WB_rd_wren),
      .stall_IF(a_stall_IF), .stall_ID(a_stall_ID), .flush_ID(a_flush_ID), .flush_EX(a_flush_EX),
      .forward_rs1_sel(a_fwd1), .forward_rs2_sel(a_fwd2), .mdu_busy(a_mdu_busy),
      .perf_stall_cnt(a_pstall), .perf_flush_cnt(a_pflush));

   hazard_unit_scoreboard #(.LOAD_LAT(3), .PERF_W(16)) u_lat3 (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr), .ID_rd_addr(ID_rd_addr),
      .ID_rd_wren(ID_rd_wren), .ID_is_mdu(ID_is_mdu),
      .EX_rs1_addr(EX_rs1_addr), .EX_rs2_addr(EX_rs2_addr), .EX_rd_addr(EX_rd_addr),
      .EX_rd_wren(EX_rd_wren), .EX_is_load(EX_is_load), .EX_br_sel(EX_br_sel),
      .EX_mdu_start(EX_mdu_start), .mdu_done(mdu_done),
      .MEM_rd_addr(MEM_rd_addr), .WB_rd_addr(WB_rd_addr),
      .MEM_rd_wren(MEM_rd_wren), .WB_rd_wren(WB_rd_wren),
      .stall_IF(b_stall_IF), .stall_ID(b_stall_ID), .flush_ID(b_flush_ID), .flush_EX(b_flush_EX),
      .forward_rs1_sel(b_fwd1), .forward_rs2_sel(b_fwd2), .mdu_busy(b_mdu_busy),
      .perf_stall_cnt(b_pstall), .perf_flush_cnt(b_pflush));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clr();
      ID_rs1_addr = 0; ID_rs2_addr = 0; ID_rd_addr = 0; ID_rd_wren = 0; ID_is_mdu = 0;
      EX_rs1_addr = 0; EX_rs2_addr = 0; EX_rd_addr = 0; EX_rd_wren = 0; EX_is_load = 0;
      EX_br_sel = 0; EX_mdu_start = 0; mdu_done = 0;
      MEM_rd_addr = 0; WB_rd_addr = 0; MEM_rd_wren = 0; WB_rd_wren = 0;
   endtask

   task automatic set_load_use();
      EX_is_load = 1; EX_rd_wren = 1; EX_rd_addr = 5; ID_rs1_addr = 5; ID_rs2_addr = 7;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " a outs"}, {a_stall_IF, a_stall_ID, a_flush_ID, a_flush_EX, a_mdu_busy}, 0);
      chk({tag, " b outs"}, {b_stall_IF, b_stall_ID, b_flush_ID, b_flush_EX, b_mdu_busy}, 0);
      chk({tag, " a perf"}, {a_pstall, a_pflush}, 0);
      chk({tag, " b perf"}, {b_pstall, b_pflush}, 0);
   endtask

   initial begin
      clr();
      i_rst_n = 0;
      #3;
      chk_all_zero("reset");
      tick();
      i_rst_n = 1;
      #1;
      chk_all_zero("post-reset");

      // load-use: both instances see the hit
      set_load_use(); #1;
      chk("ld a stall", {a_stall_IF, a_stall_ID, a_flush_EX, a_flush_ID}, 4'b1110);
      chk("ld b stall", {b_stall_IF, b_stall_ID, b_flush_EX}, 3'b111);
      tick();
      // EX now holds a bubble; the load sits in WB for the LAT=1 pipe
      clr(); EX_rs1_addr = 5; EX_rs2_addr = 7; WB_rd_addr = 5; WB_rd_wren = 1; ID_rs1_addr = 5; #1;
      chk("ld a released", a_stall_ID, 0);
      chk("ld a fwd1 wb", a_fwd1, 2'b10);
      chk("ld a fwd2", a_fwd2, 2'b00);
      chk("ld b stall2", b_stall_ID, 1);
      chk("ld b cnt2", u_lat3.r_ld_cnt, 2);
      tick();
      chk("ld b stall3", b_stall_ID, 1);
      chk("ld b cnt1", u_lat3.r_ld_cnt, 1);
      tick();
      chk("ld b released", b_stall_ID, 0);
      chk("ld b perf", b_pstall, 3);
      chk("ld a perf", a_pstall, 1);

      // forwarding priority and x0
      clr(); EX_rs1_addr = 5; EX_rs2_addr = 6;
      MEM_rd_addr = 5; MEM_rd_wren = 1; WB_rd_addr = 5; WB_rd_wren = 1; #1;
      chk("fwd mem prio", a_fwd1, 2'b01);
      chk("fwd rs2 none", a_fwd2, 2'b00);
      MEM_rd_wren = 0; WB_rd_addr = 6; #1;
      chk("fwd mem no wren", a_fwd1, 2'b00);
      chk("fwd rs2 wb", b_fwd2, 2'b10);
      EX_rs1_addr = 0; MEM_rd_addr = 0; MEM_rd_wren = 1; WB_rd_addr = 0; #1;
      chk("fwd x0", a_fwd1, 2'b00);

      // MDU scoreboard: RAW on start, RAW while busy, WAW, structural, done-cycle
      clr(); EX_mdu_start = 1; EX_rd_addr = 9; ID_rs1_addr = 9; #1;
      chk("mdu start raw", a_stall_ID, 1);
      tick();
      clr(); ID_rs2_addr = 9; #1;
      chk("mdu busy", a_mdu_busy, 1);
      chk("mdu raw", b_stall_ID, 1);
      tick();
      clr(); ID_rs1_addr = 1; ID_rd_wren = 1; ID_rd_addr = 9; #1;
      chk("mdu waw", a_stall_ID, 1);
      tick();
      clr(); ID_rs1_addr = 3; ID_rs2_addr = 4; #1;
      chk("mdu indep", a_stall_ID, 0);
      ID_is_mdu = 1; #1;
      chk("mdu struct", a_stall_ID, 1);
      tick();
      clr(); ID_rs1_addr = 9; mdu_done = 1; #1;
      chk("mdu done cycle", a_stall_ID, 1);
      tick();
      clr(); ID_rs1_addr = 9; #1;
      chk("mdu freed busy", a_mdu_busy, 0);
      chk("mdu freed stall", a_stall_ID, 0);

      // done and start in one cycle: start wins
      clr(); EX_mdu_start = 1; EX_rd_addr = 9;
      tick();
      clr(); EX_mdu_start = 1; EX_rd_addr = 12; mdu_done = 1;
      tick();
      clr(); ID_rs1_addr = 9; #1;
      chk("swap busy", a_mdu_busy, 1);
      chk("swap rd", u_lat1.r_mdu_rd, 12);
      chk("swap old free", a_stall_ID, 0);
      ID_rs1_addr = 12; #1;
      chk("swap new raw", a_stall_ID, 1);

      // branch overrides an active MDU RAW stall
      flush_before = int'(b_pflush);
      EX_br_sel = 1; #1;
      chk("br flush", {a_flush_ID, a_flush_EX, a_stall_IF, a_stall_ID}, 4'b1100);
      tick();
      chk("br perf flush", b_pflush, 16'(flush_before + 1));
      clr(); mdu_done = 1;
      tick();
      clr(); EX_is_load = 1; EX_rd_wren = 1; EX_rd_addr = 0; EX_mdu_start = 1; #1;
      chk("x0 no stall", {a_stall_ID, b_stall_ID}, 0);
      tick();
      clr(); #1;
      chk("x0 no busy", a_mdu_busy, 0);

      // async reset mid-stall with the scoreboard busy
      set_load_use(); EX_mdu_start = 1;
      tick();
      clr(); #1;
      chk("pre-rst b stall", b_stall_ID, 1);
      chk("pre-rst busy", a_mdu_busy, 1);
      i_rst_n = 0; #1;
      chk_all_zero("async rst");
      chk("rst ld cnt", u_lat3.r_ld_cnt, 0);
      tick();
      i_rst_n = 1; #1;
      chk_all_zero("rst released");

      // 20 load-use stall cycles: 4-bit counter saturates, 16-bit one does not
      set_load_use();
      for (int i = 0; i < 20; i++) tick();
      chk("sat a", a_pstall, 4'd15);
      chk("sat b", b_pstall, 16'd20);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
